// File: rtl/pipeline_stage_buf.sv
// Elastic pipeline register between two processor stages: a 1- or 2-entry in-order
// FIFO whose outputs come straight from storage registers, with flush and a stall counter.
module pipeline_stage_buf #(
  parameter int DATA_W = 149,
  parameter int CTRL_W = 18,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (DEPTH != 1 && DEPTH != 2) begin : gBadDepth
    $error("pipeline_stage_buf: DEPTH must be 1 or 2");
  end

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic              rdPtr_q, rdPtr_d;
  logic              wrPtr_q, wrPtr_d;
  logic              shownPtr_q, shownPtr_d;
  logic [1:0]        count_q, count_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              push, pop;

  function automatic logic ptrInc(input logic p);
    return (p == 1'(DEPTH - 1)) ? 1'b0 : ~p;
  endfunction

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != 2'd0);
  assign occupancy = count_q;
  assign stall_cnt = stall_q;

  // While empty, out_data keeps showing the slot that was last presented downstream.
  assign out_data = data_q[out_valid ? rdPtr_q : shownPtr_q];
  assign out_ctrl = out_valid ? ctrl_q[rdPtr_q] : '0;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    stall_d    = stall_q;
    shownPtr_d = out_valid ? rdPtr_q : shownPtr_q;

    if (flush) begin
      count_d = 2'd0;
      rdPtr_d = wrPtr_q;
    end else begin
      if (push) wrPtr_d = ptrInc(wrPtr_q);
      if (pop)  rdPtr_d = ptrInc(rdPtr_q);
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
      shownPtr_q <= 1'b0;
      count_q    <= 2'd0;
      stall_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      shownPtr_q <= shownPtr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      if (push) begin
        data_q[wrPtr_q] <= in_data;
        ctrl_q[wrPtr_q] <= in_ctrl;
      end
    end
  end

endmodule

// File: doc/pipeline_stage_buf.md
PIPELINE_STAGE_BUF -- requirements
Module: pipeline_stage_buf

Interface
REQ-001 Parameter DATA_W, default 149: width of the datapath payload (operands, immediates, register addresses).
REQ-002 Parameter CTRL_W, default 18: width of the control payload (RegWr, MemWr, MemRd, ALUFun, ...).
REQ-003 Parameter DEPTH, default 2: buffer entries; legal values are 1 and 2 only.
REQ-004 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream stage presents an instruction.
REQ-008 in_ready  output  1  buffer can accept an instruction this cycle.
REQ-009 in_data  input  DATA_W  upstream datapath payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 out_valid  output  1  head entry holds a live instruction.
REQ-012 out_ready  input  1  downstream stage consumes the head this cycle.
REQ-013 out_data  output  DATA_W  head datapath payload.
REQ-014 out_ctrl  output  CTRL_W  head control payload; all-zero when out_valid=0.
REQ-015 flush  input  1  squash all buffered and incoming instructions (taken branch/jump/IRQ).
REQ-016 occupancy  output  2  number of valid entries (0..DEPTH).
REQ-017 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-018 The buffer SHALL be an in-order FIFO of DEPTH entries; push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
REQ-019 in_ready SHALL equal (occupancy < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (occupancy != 0); out_data/out_ctrl SHALL come directly from the head register (zero input-to-output combinational path).
REQ-021 Latency SHALL be exactly 1 cycle: data pushed at edge N appears at the outputs after edge N when the buffer was empty.
REQ-022 When out_valid=0, out_ctrl SHALL be forced to all-zero (bubble: no register or memory write downstream); out_data SHALL hold its last value.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged, advance the head, and preserve order.
REQ-024 With DEPTH=2, sustained in_valid=out_ready=1 SHALL yield one transfer per cycle; with DEPTH=1, at most one transfer every 2 cycles.
REQ-025 flush=1 SHALL set occupancy to 0 at the next edge, discard any same-cycle push, and suppress any same-cycle pop; flush has priority over all other events.
REQ-026 Head/tail pointers SHALL wrap modulo DEPTH; the write pointer SHALL never overtake the read pointer (push blocked when full).
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0 and flush=0, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-028 Elaboration with DEPTH outside {1,2} SHALL be a compile-time error.

Reset
REQ-029 On reset=1 at an edge: occupancy=0, pointers=0, stall_cnt=0, stored payloads=0; thus out_valid=0, out_ctrl=0, out_data=0, in_ready=1 after that edge.
REQ-030 Reset SHALL take priority over flush, push and pop; an instruction presented during reset SHALL be discarded.
REQ-031 Reset asserted mid-stream with occupancy=2 SHALL empty the buffer in one cycle with no entry emitted afterwards.

Verification
REQ-032 DEPTH=2, push A=0x1 then B=0x2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x1, stall_cnt increments every cycle; raise out_ready -> A then B emitted on consecutive cycles.
REQ-033 DEPTH=2, in_valid=out_ready=1 for 10 cycles with payload 0..9 -> outputs 0..9 in order, one per cycle, occupancy steady at 1.
REQ-034 occupancy=2 and in_valid=1, flush=1 for one cycle -> next cycle occupancy=0, out_valid=0, out_ctrl=0, flushed/incoming entries never appear.
REQ-035 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds at 15.
REQ-036 DEPTH=1, continuous in_valid=out_ready=1 -> in_ready toggles, one transfer every 2 cycles, no loss or duplication.
REQ-037 reset=1 with occupancy=2 and in_valid=1 -> after edge occupancy=0, stall_cnt=0, out_ctrl=0, in_ready=1.
